rmt_dest_demux: RTL and testbench

RMT_DEST_DEMUX -- requirements
Module: rmt_dest_demux

---
 rtl/rmt_dest_demux_if.sv | 42 ++++
 rtl/rmt_dest_demux.sv | 231 +++++++++++++++++++++++
 tb/tb_rmt_dest_demux.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/rmt_dest_demux_if.sv
// AXI-Stream style bundle for the destination demux. LANES = 1 gives the
// single ingress stream; LANES = PORT_COUNT gives the per-port egress
// streams, with lane i occupying slice i of every vector.
interface rmt_dest_demux_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int USER_WIDTH = 8,
  parameter int DEST_WIDTH = 2,
  parameter int LANES      = 1
);

  logic [LANES*DATA_WIDTH-1:0] tdata;
  logic [LANES*KEEP_WIDTH-1:0] tkeep;
  logic [LANES-1:0]            tvalid;
  logic [LANES-1:0]            tready;
  logic [LANES-1:0]            tlast;
  logic [LANES*USER_WIDTH-1:0] tuser;
  logic [LANES*DEST_WIDTH-1:0] tdest;

  // Stream source: drives payload and valid, observes ready.
  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    output tuser,
    output tdest,
    input  tready
  );

  // Stream sink: observes payload and valid, drives ready.
  modport slave (
    input  tdata,
    input  tkeep,
    input  tvalid,
    input  tlast,
    input  tuser,
    input  tdest,
    output tready
  );

endinterface

// File: rtl/rmt_dest_demux.sv
// Destination demultiplexer: routes each ingress frame to the egress port
// named by the tdest of its first beat. Frames whose tdest is out of range
// are discarded and counted. One shared output register plus a skid
// register carry the port index with every beat, so back-to-back frames to
// different ports need no bubble.
module rmt_dest_demux #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int USER_WIDTH = 8,
  parameter int PORT_COUNT = 2,
  parameter int DEST_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  rmt_dest_demux_if.slave       s_axis,
  rmt_dest_demux_if.master      m_axis,
  output logic [15:0]           stat_drop_count,
  output logic                  stat_drop_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // PORT_COUNT may equal 2**DEST_WIDTH, so compare with one extra bit.
  localparam logic [DEST_WIDTH:0] PORT_LIMIT = (DEST_WIDTH + 1)'(PORT_COUNT);

  // Frame state
  state_e                  state_q;
  logic [DEST_WIDTH-1:0]   sel_port_q;
  logic [15:0]             drop_count_q;
  logic                    drop_pulse_q;

  // Output register
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q,  out_data_d;
  logic [KEEP_WIDTH-1:0]   out_keep_q,  out_keep_d;
  logic                    out_last_q,  out_last_d;
  logic [USER_WIDTH-1:0]   out_user_q,  out_user_d;
  logic [DEST_WIDTH-1:0]   out_port_q,  out_port_d;

  // Skid register
  logic                    skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0]   skid_data_q,  skid_data_d;
  logic [KEEP_WIDTH-1:0]   skid_keep_q,  skid_keep_d;
  logic                    skid_last_q,  skid_last_d;
  logic [USER_WIDTH-1:0]   skid_user_q,  skid_user_d;
  logic [DEST_WIDTH-1:0]   skid_port_q,  skid_port_d;

  // Ingress ready register
  logic                    s_ready_q;

  // Combinational helpers
  logic                    acc_s;
  logic                    in_range_s;
  logic                    fwd_s;
  logic [DEST_WIDTH-1:0]   beat_port_s;
  logic                    out_ready_s;
  logic                    drain_s;

  // Classify the ingress beat: accepted, forwarded, and to which port.
  always_comb begin
    acc_s       = s_axis.tvalid[0] & s_ready_q;
    in_range_s  = ({1'b0, s_axis.tdest} < PORT_LIMIT);
    fwd_s       = 1'b0;
    beat_port_s = sel_port_q;
    case (state_q)
      ST_IDLE: begin
        fwd_s       = acc_s & in_range_s;
        beat_port_s = s_axis.tdest;
      end
      ST_FWD: begin
        fwd_s       = acc_s;
        beat_port_s = sel_port_q;
      end
      ST_DROP: begin
        fwd_s       = 1'b0;
        beat_port_s = sel_port_q;
      end
      default: begin
        fwd_s       = 1'b0;
        beat_port_s = sel_port_q;
      end
    endcase
  end

  // The output register drains only on the ready of the port it targets.
  always_comb begin
    out_ready_s = 1'b0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      out_ready_s = out_ready_s | (m_axis.tready[i] & (out_port_q == DEST_WIDTH'(i)));
    end
    drain_s = out_valid_q & out_ready_s;
  end

  // Next state of the output and skid registers.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_last_d   = out_last_q;
    out_user_d   = out_user_q;
    out_port_d   = out_port_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_keep_d  = skid_keep_q;
    skid_last_d  = skid_last_q;
    skid_user_d  = skid_user_q;
    skid_port_d  = skid_port_q;
    if (!out_valid_q || drain_s) begin
      if (skid_valid_q) begin
        // Ingress was held off while the skid was full, so no new beat
        // competes with the skid for the output register here.
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_keep_d   = skid_keep_q;
        out_last_d   = skid_last_q;
        out_user_d   = skid_user_q;
        out_port_d   = skid_port_q;
        skid_valid_d = 1'b0;
      end else if (fwd_s) begin
        out_valid_d  = 1'b1;
        out_data_d   = s_axis.tdata;
        out_keep_d   = s_axis.tkeep;
        out_last_d   = s_axis.tlast[0];
        out_user_d   = s_axis.tuser;
        out_port_d   = beat_port_s;
      end else begin
        out_valid_d  = 1'b0;
      end
    end else begin
      if (fwd_s) begin
        // Output stalled: park the beat that arrived on the ready we
        // already advertised.
        skid_valid_d = 1'b1;
        skid_data_d  = s_axis.tdata;
        skid_keep_d  = s_axis.tkeep;
        skid_last_d  = s_axis.tlast[0];
        skid_user_d  = s_axis.tuser;
        skid_port_d  = beat_port_s;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
  end

  // Register the datapath; ingress ready follows skid occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
      out_user_q   <= '0;
      out_port_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_keep_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_user_q  <= '0;
      skid_port_q  <= '0;
      s_ready_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_last_q   <= out_last_d;
      out_user_q   <= out_user_d;
      out_port_q   <= out_port_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_keep_q  <= skid_keep_d;
      skid_last_q  <= skid_last_d;
      skid_user_q  <= skid_user_d;
      skid_port_q  <= skid_port_d;
      s_ready_q    <= ~skid_valid_d;
    end
  end

  // Frame FSM: latch the port on the first beat, track frame end, count drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_port_q   <= '0;
      drop_count_q <= 16'h0000;
      drop_pulse_q <= 1'b0;
    end else begin
      drop_pulse_q <= 1'b0;
      if (acc_s) begin
        case (state_q)
          ST_IDLE: begin
            if (in_range_s) begin
              sel_port_q <= s_axis.tdest;
              state_q    <= s_axis.tlast[0] ? ST_IDLE : ST_FWD;
            end else begin
              drop_count_q <= drop_count_q + 16'd1;
              drop_pulse_q <= 1'b1;
              state_q      <= s_axis.tlast[0] ? ST_IDLE : ST_DROP;
            end
          end
          ST_FWD: begin
            state_q <= s_axis.tlast[0] ? ST_IDLE : ST_FWD;
          end
          ST_DROP: begin
            state_q <= s_axis.tlast[0] ? ST_IDLE : ST_DROP;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Egress decode: payload is shared, only the addressed port sees valid.
  for (genvar g = 0; g < PORT_COUNT; g++) begin : g_port
    assign m_axis.tvalid[g] = out_valid_q & (out_port_q == DEST_WIDTH'(g));
  end

  assign m_axis.tdata     = {PORT_COUNT{out_data_q}};
  assign m_axis.tkeep     = {PORT_COUNT{out_keep_q}};
  assign m_axis.tlast     = {PORT_COUNT{out_last_q}};
  assign m_axis.tuser     = {PORT_COUNT{out_user_q}};
  assign m_axis.tdest     = {PORT_COUNT{out_port_q}};
  assign s_axis.tready[0] = s_ready_q;
  assign stat_drop_count  = drop_count_q;
  assign stat_drop_pulse  = drop_pulse_q;

endmodule

// File: tb/tb_rmt_dest_demux.sv
// Directed bench for rmt_dest_demux with PORT_COUNT=2, DEST_WIDTH=2,
// 8-bit data. Inputs change 1 time unit after a rising edge and outputs are
// checked at that same point, i.e. they reflect the edge just taken.
module tb_rmt_dest_demux;

  logic        clk;
  logic        rst;
  logic [15:0] stat_drop_count;
  logic        stat_drop_pulse;
  int          tests;
  int          fails;

  rmt_dest_demux_if #(.DATA_WIDTH(8), .USER_WIDTH(8), .DEST_WIDTH(2), .LANES(1)) s_if ();
  rmt_dest_demux_if #(.DATA_WIDTH(8), .USER_WIDTH(8), .DEST_WIDTH(2), .LANES(2)) m_if ();

  rmt_dest_demux #(
    .DATA_WIDTH(8),
    .USER_WIDTH(8),
    .PORT_COUNT(2),
    .DEST_WIDTH(2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .s_axis          (s_if),
    .m_axis          (m_if),
    .stat_drop_count (stat_drop_count),
    .stat_drop_pulse (stat_drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] dest, input logic l);
    s_if.tvalid = v;
    s_if.tdata  = d;
    s_if.tkeep  = 1'b1;
    s_if.tuser  = d ^ 8'h5A;
    s_if.tdest  = dest;
    s_if.tlast  = l;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the valid vector and, when a beat is presented, its payload on port p.
  task automatic chk_out(input string tag, input logic [1:0] exp_v, input int p,
                         input logic [7:0] d, input logic l);
    chk({tag, "_vld"}, 32'(m_if.tvalid), 32'(exp_v));
    if (exp_v != 2'b00) begin
      chk({tag, "_dat"}, 32'(m_if.tdata[p*8 +: 8]), 32'(d));
      chk({tag, "_usr"}, 32'(m_if.tuser[p*8 +: 8]), 32'(d ^ 8'h5A));
      chk({tag, "_kep"}, 32'(m_if.tkeep[p]), 32'd1);
      chk({tag, "_lst"}, 32'(m_if.tlast[p]), 32'(l));
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    m_if.tready = 2'b11;
    drive(1'b0, 8'h00, 2'd0, 1'b0);

    // Reset state
    tick();
    tick();
    chk_out("rst", 2'b00, 0, 8'h00, 1'b0);
    chk("rst_srdy", 32'(s_if.tready), 32'd0);
    chk("rst_cnt", 32'(stat_drop_count), 32'd0);
    chk("rst_pls", 32'(stat_drop_pulse), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_srdy", 32'(s_if.tready), 32'd1);

    // 3-beat frame to port 1
    drive(1'b1, 8'h11, 2'd1, 1'b0); tick(); chk_out("f1_b1", 2'b10, 1, 8'h11, 1'b0);
    drive(1'b1, 8'h12, 2'd1, 1'b0); tick(); chk_out("f1_b2", 2'b10, 1, 8'h12, 1'b0);
    drive(1'b1, 8'h13, 2'd1, 1'b1); tick(); chk_out("f1_b3", 2'b10, 1, 8'h13, 1'b1);
    chk("f1_srdy", 32'(s_if.tready), 32'd1);
    drive(1'b0, 8'h00, 2'd0, 1'b0); tick(); chk_out("f1_end", 2'b00, 0, 8'h00, 1'b0);

    // 4-beat frame to tdest=3 is dropped
    drive(1'b1, 8'h21, 2'd3, 1'b0); tick();
    chk_out("drop_b1", 2'b00, 0, 8'h00, 1'b0);
    chk("drop_pls1", 32'(stat_drop_pulse), 32'd1);
    chk("drop_cnt1", 32'(stat_drop_count), 32'd1);
    drive(1'b1, 8'h22, 2'd0, 1'b0); tick();
    chk_out("drop_b2", 2'b00, 0, 8'h00, 1'b0);
    chk("drop_pls2", 32'(stat_drop_pulse), 32'd0);
    drive(1'b1, 8'h23, 2'd1, 1'b0); tick();
    chk_out("drop_b3", 2'b00, 0, 8'h00, 1'b0);
    chk("drop_pls3", 32'(stat_drop_pulse), 32'd0);
    drive(1'b1, 8'h24, 2'd3, 1'b1); tick();
    chk_out("drop_b4", 2'b00, 0, 8'h00, 1'b0);
    chk("drop_pls4", 32'(stat_drop_pulse), 32'd0);
    chk("drop_cnt4", 32'(stat_drop_count), 32'd1);
    // Back in IDLE: a fresh single-beat frame to port 0 is forwarded
    drive(1'b1, 8'h2F, 2'd0, 1'b1); tick();
    chk_out("drop_idle", 2'b01, 0, 8'h2F, 1'b1);
    drive(1'b0, 8'h00, 2'd0, 1'b0); tick(); chk_out("drop_end", 2'b00, 0, 8'h00, 1'b0);

    // Port 0 stalled for 5 cycles while port 1 stays ready
    m_if.tready = 2'b10;
    drive(1'b1, 8'h30, 2'd0, 1'b0); tick();
    chk_out("stl_e0", 2'b01, 0, 8'h30, 1'b0);
    chk("stl_srdy0", 32'(s_if.tready), 32'd1);
    drive(1'b1, 8'h31, 2'd0, 1'b0); tick();
    chk_out("stl_hold1", 2'b01, 0, 8'h30, 1'b0);
    chk("stl_srdy1", 32'(s_if.tready), 32'd0);
    drive(1'b1, 8'h32, 2'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out("stl_hold", 2'b01, 0, 8'h30, 1'b0);
      chk("stl_srdy", 32'(s_if.tready), 32'd0);
    end
    m_if.tready = 2'b11;
    tick();
    chk_out("rel_e1", 2'b01, 0, 8'h31, 1'b0);
    chk("rel_srdy", 32'(s_if.tready), 32'd1);
    tick();
    chk_out("rel_e2", 2'b01, 0, 8'h32, 1'b0);
    drive(1'b1, 8'h33, 2'd0, 1'b1); tick();
    chk_out("rel_e3", 2'b01, 0, 8'h33, 1'b1);
    drive(1'b0, 8'h00, 2'd0, 1'b0); tick(); chk_out("rel_end", 2'b00, 0, 8'h00, 1'b0);

    // Back-to-back frames to different ports
    drive(1'b1, 8'h40, 2'd0, 1'b1); tick(); chk_out("b2b_a", 2'b01, 0, 8'h40, 1'b1);
    drive(1'b1, 8'h41, 2'd1, 1'b0); tick(); chk_out("b2b_b0", 2'b10, 1, 8'h41, 1'b0);
    drive(1'b1, 8'h42, 2'd1, 1'b1); tick(); chk_out("b2b_b1", 2'b10, 1, 8'h42, 1'b1);
    drive(1'b0, 8'h00, 2'd0, 1'b0); tick(); chk_out("b2b_end", 2'b00, 0, 8'h00, 1'b0);

    // tdest changes mid-frame; beats stay on the first beat's port
    drive(1'b1, 8'h50, 2'd1, 1'b0); tick(); chk_out("tdc_b1", 2'b10, 1, 8'h50, 1'b0);
    drive(1'b0, 8'h00, 2'd0, 1'b0); tick(); chk_out("tdc_gap", 2'b00, 0, 8'h00, 1'b0);
    drive(1'b1, 8'h51, 2'd0, 1'b0); tick(); chk_out("tdc_b2", 2'b10, 1, 8'h51, 1'b0);
    drive(1'b1, 8'h52, 2'd0, 1'b1); tick(); chk_out("tdc_b3", 2'b10, 1, 8'h52, 1'b1);
    drive(1'b0, 8'h00, 2'd0, 1'b0); tick(); chk_out("tdc_end", 2'b00, 0, 8'h00, 1'b0);

    // Reset mid-frame with both registers occupied
    m_if.tready = 2'b00;
    drive(1'b1, 8'h60, 2'd0, 1'b0); tick(); chk_out("mrst_f0", 2'b01, 0, 8'h60, 1'b0);
    drive(1'b1, 8'h61, 2'd0, 1'b0); tick(); chk("mrst_full", 32'(s_if.tready), 32'd0);
    rst = 1'b1;
    drive(1'b0, 8'h00, 2'd0, 1'b0); tick();
    chk_out("mrst", 2'b00, 0, 8'h00, 1'b0);
    chk("mrst_cnt", 32'(stat_drop_count), 32'd0);
    chk("mrst_srdy", 32'(s_if.tready), 32'd0);
    rst = 1'b0;
    tick();
    chk("mrst_srdy1", 32'(s_if.tready), 32'd1);
    chk_out("mrst_idle", 2'b00, 0, 8'h00, 1'b0);
    m_if.tready = 2'b11;
    drive(1'b1, 8'h70, 2'd1, 1'b0); tick(); chk_out("mrst_g0", 2'b10, 1, 8'h70, 1'b0);
    drive(1'b1, 8'h71, 2'd0, 1'b1); tick(); chk_out("mrst_g1", 2'b10, 1, 8'h71, 1'b1);
    drive(1'b0, 8'h00, 2'd0, 1'b0); tick(); chk_out("mrst_end", 2'b00, 0, 8'h00, 1'b0);

    // Drop counter wraps after 65536 single-beat dropped frames
    drive(1'b1, 8'h80, 2'd2, 1'b1);
    for (int k = 0; k < 65535; k++) begin
      tick();
    end
    chk("wrap_ffff", 32'(stat_drop_count), 32'h0000FFFF);
    chk("wrap_pls", 32'(stat_drop_pulse), 32'd1);
    chk_out("wrap_vld", 2'b00, 0, 8'h00, 1'b0);
    tick();
    chk("wrap_zero", 32'(stat_drop_count), 32'h00000000);
    drive(1'b0, 8'h00, 2'd0, 1'b0); tick();
    chk("wrap_pls0", 32'(stat_drop_pulse), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
